// File: rtl/control_pkg.sv
// Shared types and constants for the accumulator-core sequencer.
// The PAUSE state exists only when CONTROL_SINGLE_STEP_EN is defined.
package control_pkg;

  localparam int OPCODE_WIDTH = 5;
  localparam int ALU_OP_WIDTH = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_HLT  = 5'h00, OP_STO  = 5'h01, OP_LD   = 5'h02, OP_LDI  = 5'h03,
    OP_ADD  = 5'h04, OP_ADDI = 5'h05, OP_SUB  = 5'h06, OP_SUBI = 5'h07,
    OP_AND  = 5'h08, OP_ANDI = 5'h09, OP_OR   = 5'h0A, OP_ORI  = 5'h0B,
    OP_XOR  = 5'h0C, OP_XORI = 5'h0D, OP_NOT  = 5'h0E, OP_BEQ  = 5'h0F,
    OP_BNE  = 5'h10, OP_BGT  = 5'h11, OP_BGE  = 5'h12, OP_BLT  = 5'h13,
    OP_BLE  = 5'h14, OP_JMP  = 5'h15, OP_NOP  = 5'h16
  } opcode_t;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_PASS_B = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_AND = 3'd3,
    ALU_OR     = 3'd4, ALU_XOR = 3'd5, ALU_NOT = 3'd6
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_INIT, ST_FETCH, ST_DECODE, ST_MEMOP, ST_EXEC, ST_STORE, ST_HALT
`ifdef CONTROL_SINGLE_STEP_EN
    , ST_PAUSE
`endif
  } state_t;

  typedef struct packed {
    logic    pc_clr;
    logic    pc_inc;
    logic    pc_wr;
    logic    ir_wr;
    logic    addr_sel;
    logic    mem_rd;
    logic    mem_wr;
    logic    b_sel;
    alu_op_t alu_op;
    logic    acc_wr;
    logic    flags_wr;
    logic    flags_reset;
    logic    illegal_op;
  } strobes_t;

  // Register and immediate forms of an operation share one ALU select.
  function automatic alu_op_t alu_sel(input logic [OPCODE_WIDTH-1:0] op);
    case (op)
      OP_ADD, OP_ADDI: alu_sel = ALU_ADD;
      OP_SUB, OP_SUBI: alu_sel = ALU_SUB;
      OP_AND, OP_ANDI: alu_sel = ALU_AND;
      OP_OR,  OP_ORI:  alu_sel = ALU_OR;
      OP_XOR, OP_XORI: alu_sel = ALU_XOR;
      OP_NOT:          alu_sel = ALU_NOT;
      default:         alu_sel = ALU_PASS_B;
    endcase
  endfunction

endpackage

// File: rtl/control_branch_eval.sv
// Branch condition evaluation from the Z/N flags; non-branch opcodes are never taken.
module branch_eval
  import control_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    flag_Z,
  input  logic                    flag_N,
  output logic                    taken
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = flag_Z;
      OP_BNE:  taken = ~flag_Z;
      OP_BGT:  taken = ~flag_Z & ~flag_N;
      OP_BGE:  taken = ~flag_N;
      OP_BLT:  taken = flag_N;
      OP_BLE:  taken = flag_N | flag_Z;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 11-bit accumulator datapath.
// Optional single-step pause is enabled with CONTROL_SINGLE_STEP_EN.
module control_unit
  import control_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                    clock,
  input  logic                    control_reset,
`ifdef CONTROL_SINGLE_STEP_EN
  input  logic                    step,
`endif
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    flag_Z,
  input  logic                    flag_N,
  input  logic                    mem_ready,
  output logic                    pc_clr,
  output logic                    pc_inc,
  output logic                    pc_wr,
  output logic                    ir_wr,
  output logic                    addr_sel,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic                    b_sel,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    acc_wr,
  output logic                    flags_wr,
  output logic                    flags_reset,
  output logic                    halted,
  output logic                    illegal_op,
  output logic                    bus_error
);

  localparam int CNT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

`ifdef CONTROL_SINGLE_STEP_EN
  localparam state_t RESUME = ST_PAUSE;
  logic stepPrev_q;
`else
  localparam state_t RESUME = ST_FETCH;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic             busErr_q, busErr_d;
  logic             taken;
  logic             waitExpired;
  strobes_t         strbRaw, strb;

  branch_eval u_branch_eval (
    .opcode (opcode),
    .flag_Z (flag_Z),
    .flag_N (flag_N),
    .taken  (taken)
  );

  // The last permitted wait cycle: the request is dropped on the following edge.
  assign waitExpired = (MEM_WAIT_MAX != 0) && (int'(waitCnt_q) == MEM_WAIT_MAX - 1);

  always_comb begin
    state_d   = state_q;
    waitCnt_d = '0;
    busErr_d  = busErr_q;
    strbRaw   = '0;
    case (state_q)
      ST_INIT: begin
        strbRaw.pc_clr      = 1'b1;
        strbRaw.flags_reset = 1'b1;
        state_d             = ST_FETCH;
      end
      ST_FETCH: begin
        strbRaw.mem_rd = 1'b1;
        if (mem_ready) begin
          strbRaw.ir_wr  = 1'b1;
          strbRaw.pc_inc = 1'b1;
          state_d        = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_HLT: state_d = ST_HALT;
          OP_STO: state_d = ST_STORE;
          OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = ST_MEMOP;
          OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_NOT: state_d = ST_EXEC;
          OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: begin
            strbRaw.pc_wr = taken;
            state_d       = RESUME;
          end
          OP_NOP: state_d = RESUME;
          default: begin
            strbRaw.illegal_op = 1'b1;
            state_d            = RESUME;
          end
        endcase
      end
      ST_MEMOP: begin
        strbRaw.mem_rd   = 1'b1;
        strbRaw.addr_sel = 1'b1;
        if (mem_ready) begin
          strbRaw.acc_wr   = 1'b1;
          strbRaw.flags_wr = 1'b1;
          strbRaw.alu_op   = alu_sel(opcode);
          state_d          = RESUME;
        end
      end
      ST_EXEC: begin
        strbRaw.b_sel    = 1'b1;
        strbRaw.acc_wr   = 1'b1;
        strbRaw.flags_wr = 1'b1;
        strbRaw.alu_op   = alu_sel(opcode);
        state_d          = RESUME;
      end
      ST_STORE: begin
        strbRaw.mem_wr   = 1'b1;
        strbRaw.addr_sel = 1'b1;
        if (mem_ready) state_d = RESUME;
      end
`ifdef CONTROL_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (step && !stepPrev_q) state_d = ST_FETCH;
      end
`endif
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_INIT;
    endcase

    if ((state_q == ST_FETCH || state_q == ST_MEMOP || state_q == ST_STORE) && !mem_ready) begin
      if (waitExpired) begin
        state_d  = ST_HALT;
        busErr_d = 1'b1;
      end else begin
        waitCnt_d = waitCnt_q + 1'b1;
      end
    end
  end

  // Gating with the reset level clears every strobe without waiting for a clock.
  assign strb        = control_reset ? strbRaw : '0;
  assign pc_clr      = strb.pc_clr;
  assign pc_inc      = strb.pc_inc;
  assign pc_wr       = strb.pc_wr;
  assign ir_wr       = strb.ir_wr;
  assign addr_sel    = strb.addr_sel;
  assign mem_rd      = strb.mem_rd;
  assign mem_wr      = strb.mem_wr;
  assign b_sel       = strb.b_sel;
  assign alu_op      = strb.alu_op;
  assign acc_wr      = strb.acc_wr;
  assign flags_wr    = strb.flags_wr;
  assign flags_reset = strb.flags_reset;
  assign illegal_op  = strb.illegal_op;
  assign halted      = control_reset && (state_q == ST_HALT);
  assign bus_error   = busErr_q;

  always_ff @(posedge clock or negedge control_reset) begin
    if (!control_reset) begin
      state_q   <= ST_INIT;
      waitCnt_q <= '0;
      busErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      busErr_q  <= busErr_d;
    end
  end

`ifdef CONTROL_SINGLE_STEP_EN
  always_ff @(posedge clock or negedge control_reset) begin
    if (!control_reset) stepPrev_q <= 1'b0;
    else                stepPrev_q <= step;
  end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed cycle-by-cycle bench for control_unit; every cycle's full strobe vector
// is queued as an expectation and compared against the DUT half a cycle later.
module tb_control_unit;

  logic       clock = 1'b0;
  logic       control_reset = 1'b0;
  logic       step = 1'b0;
  logic [4:0] opcode = 5'h16;
  logic       flag_Z = 1'b0;
  logic       flag_N = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_clr, pc_inc, pc_wr, ir_wr, addr_sel, mem_rd, mem_wr, b_sel;
  logic [2:0] alu_op;
  logic       acc_wr, flags_wr, flags_reset, halted, illegal_op, bus_error;

  int errors = 0;
  int checks = 0;

  localparam logic [16:0] PC_CLR      = 17'h10000;
  localparam logic [16:0] PC_INC      = 17'h08000;
  localparam logic [16:0] PC_WR       = 17'h04000;
  localparam logic [16:0] IR_WR       = 17'h02000;
  localparam logic [16:0] ADDR_SEL    = 17'h01000;
  localparam logic [16:0] MEM_RD      = 17'h00800;
  localparam logic [16:0] MEM_WR      = 17'h00400;
  localparam logic [16:0] B_SEL       = 17'h00200;
  localparam logic [16:0] ACC_WR      = 17'h00020;
  localparam logic [16:0] FLAGS_WR    = 17'h00010;
  localparam logic [16:0] FLAGS_RESET = 17'h00008;
  localparam logic [16:0] HALTED      = 17'h00004;
  localparam logic [16:0] ILLEGAL     = 17'h00002;
  localparam logic [16:0] BUS_ERROR   = 17'h00001;
  localparam logic [16:0] FETCH_OK    = MEM_RD | IR_WR | PC_INC;
  localparam logic [16:0] NONE        = 17'h00000;

  function automatic logic [16:0] aluField(input int op);
    aluField = 17'(op) << 6;
  endfunction

  typedef struct {
    string       tag;
    logic [16:0] vec;
  } expect_t;

  expect_t scoreboard[$];

  control_unit #(.MEM_WAIT_MAX(15)) dut (
    .clock         (clock),
    .control_reset (control_reset),
`ifdef CONTROL_SINGLE_STEP_EN
    .step          (step),
`endif
    .opcode        (opcode),
    .flag_Z        (flag_Z),
    .flag_N        (flag_N),
    .mem_ready     (mem_ready),
    .pc_clr        (pc_clr),
    .pc_inc        (pc_inc),
    .pc_wr         (pc_wr),
    .ir_wr         (ir_wr),
    .addr_sel      (addr_sel),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .b_sel         (b_sel),
    .alu_op        (alu_op),
    .acc_wr        (acc_wr),
    .flags_wr      (flags_wr),
    .flags_reset   (flags_reset),
    .halted        (halted),
    .illegal_op    (illegal_op),
    .bus_error     (bus_error)
  );

  always #5 clock = ~clock;

  task automatic checkOutput();
    expect_t     e;
    logic [16:0] observed;
    observed = {pc_clr, pc_inc, pc_wr, ir_wr, addr_sel, mem_rd, mem_wr, b_sel,
                alu_op, acc_wr, flags_wr, flags_reset, halted, illegal_op, bus_error};
    e = scoreboard.pop_front();
    checks++;
    assert (observed === e.vec)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%05h expected=%05h", e.tag, observed, e.vec);
    end
  endtask

  // One clock: inputs change just after the edge, outputs are checked on the falling edge.
  task automatic applyStimulus(input string tag, input logic rstn, input logic [4:0] opc,
                               input logic rdy, input logic z, input logic n,
                               input logic [16:0] expv);
    @(posedge clock);
    #1;
    control_reset = rstn;
    opcode        = opc;
    mem_ready     = rdy;
    flag_Z        = z;
    flag_N        = n;
    scoreboard.push_back('{tag, expv});
    @(negedge clock);
    checkOutput();
  endtask

  initial begin
    applyStimulus("reset_a", 1'b0, 5'h16, 1'b0, 1'b0, 1'b0, NONE);
    applyStimulus("reset_b", 1'b0, 5'h16, 1'b1, 1'b1, 1'b1, NONE);
    applyStimulus("init", 1'b1, 5'h16, 1'b0, 1'b0, 1'b0, PC_CLR | FLAGS_RESET);
    applyStimulus("fetch_wait", 1'b1, 5'h03, 1'b0, 1'b0, 1'b0, MEM_RD);

    // LDI: fetch, decode, exec in three cycles
    applyStimulus("ldi_fetch", 1'b1, 5'h03, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("ldi_decode", 1'b1, 5'h03, 1'b1, 1'b0, 1'b0, NONE);
    applyStimulus("ldi_exec", 1'b1, 5'h03, 1'b1, 1'b0, 1'b0, B_SEL | ACC_WR | FLAGS_WR | aluField(0));

    applyStimulus("not_fetch", 1'b1, 5'h0E, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("not_decode", 1'b1, 5'h0E, 1'b1, 1'b0, 1'b0, NONE);
    applyStimulus("not_exec", 1'b1, 5'h0E, 1'b1, 1'b0, 1'b0, B_SEL | ACC_WR | FLAGS_WR | aluField(6));

    // ADD with memory ready after four wait cycles
    applyStimulus("add_fetch", 1'b1, 5'h04, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("add_decode", 1'b1, 5'h04, 1'b1, 1'b0, 1'b0, NONE);
    for (int i = 0; i < 4; i++)
      applyStimulus("add_memop_wait", 1'b1, 5'h04, 1'b0, 1'b0, 1'b0, MEM_RD | ADDR_SEL);
    applyStimulus("add_memop_ready", 1'b1, 5'h04, 1'b1, 1'b0, 1'b0,
                  MEM_RD | ADDR_SEL | ACC_WR | FLAGS_WR | aluField(1));

    // Conditional branches
    applyStimulus("blt_fetch", 1'b1, 5'h13, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("blt_n1_taken", 1'b1, 5'h13, 1'b1, 1'b0, 1'b1, PC_WR);
    applyStimulus("blt_fetch2", 1'b1, 5'h13, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("blt_n0_not_taken", 1'b1, 5'h13, 1'b1, 1'b0, 1'b0, NONE);
    applyStimulus("ble_fetch", 1'b1, 5'h14, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("ble_z1_taken", 1'b1, 5'h14, 1'b1, 1'b1, 1'b0, PC_WR);
    applyStimulus("bne_fetch", 1'b1, 5'h10, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("bne_z1_not_taken", 1'b1, 5'h10, 1'b1, 1'b1, 1'b0, NONE);
    applyStimulus("bgt_fetch", 1'b1, 5'h11, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("bgt_clear_taken", 1'b1, 5'h11, 1'b1, 1'b0, 1'b0, PC_WR);

    // Undefined opcode behaves as NOP with a one-cycle flag
    applyStimulus("ill_fetch", 1'b1, 5'h1F, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("ill_decode", 1'b1, 5'h1F, 1'b1, 1'b0, 1'b0, ILLEGAL);
    applyStimulus("ill_next_fetch", 1'b1, 5'h1F, 1'b0, 1'b0, 1'b0, MEM_RD);

    // Store that never completes: 15 wait cycles, then bus error
    applyStimulus("sto_fetch", 1'b1, 5'h01, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("sto_decode", 1'b1, 5'h01, 1'b1, 1'b0, 1'b0, NONE);
    for (int i = 0; i < 15; i++)
      applyStimulus("sto_wait", 1'b1, 5'h01, 1'b0, 1'b0, 1'b0, MEM_WR | ADDR_SEL);
    for (int i = 0; i < 3; i++)
      applyStimulus("timeout_halt", 1'b1, 5'h01, i[0], 1'b0, 1'b0, HALTED | BUS_ERROR);

    // Completed store, then reset asserted in the middle of a store wait
    applyStimulus("reset2", 1'b0, 5'h16, 1'b0, 1'b0, 1'b0, NONE);
    applyStimulus("init2", 1'b1, 5'h01, 1'b0, 1'b0, 1'b0, PC_CLR | FLAGS_RESET);
    applyStimulus("sto2_fetch", 1'b1, 5'h01, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("sto2_decode", 1'b1, 5'h01, 1'b1, 1'b0, 1'b0, NONE);
    applyStimulus("sto2_wait", 1'b1, 5'h01, 1'b0, 1'b0, 1'b0, MEM_WR | ADDR_SEL);
    applyStimulus("sto2_ready", 1'b1, 5'h01, 1'b1, 1'b0, 1'b0, MEM_WR | ADDR_SEL);
    applyStimulus("nop_fetch", 1'b1, 5'h16, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("nop_decode", 1'b1, 5'h16, 1'b1, 1'b0, 1'b0, NONE);
    applyStimulus("sto3_fetch", 1'b1, 5'h01, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("sto3_decode", 1'b1, 5'h01, 1'b1, 1'b0, 1'b0, NONE);
    for (int i = 0; i < 3; i++)
      applyStimulus("sto3_wait", 1'b1, 5'h01, 1'b0, 1'b0, 1'b0, MEM_WR | ADDR_SEL);
    applyStimulus("reset_mid_wait", 1'b0, 5'h01, 1'b0, 1'b0, 1'b0, NONE);

    // HLT holds every strobe low until reset
    applyStimulus("init3", 1'b1, 5'h00, 1'b0, 1'b0, 1'b0, PC_CLR | FLAGS_RESET);
    applyStimulus("hlt_fetch", 1'b1, 5'h00, 1'b1, 1'b0, 1'b0, FETCH_OK);
    applyStimulus("hlt_decode", 1'b1, 5'h00, 1'b1, 1'b0, 1'b0, NONE);
    for (int i = 0; i < 22; i++)
      applyStimulus("halt_hold", 1'b1, 5'h04, i[0], i[1], i[2], HALTED);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
